adc124_responder: RTL and testbench

Cycle-accurate SPI responder that emulates the four-channel, 12-bit ADC124 serial converter on the slave side of the CS_n/SCLK/MOSI/MISO link. It decodes the channel address the master shifts in on MOSI and serializes the previously addressed channel's 12-bit value on MISO. It is used in simulation and hardware-in-the-loop builds of the FOC current path, standing in for the physical converter at the other end of the ADC124 pins. Channel values are supplied by a plant model or test logic.

---
 rtl/adc124_responder.sv | 192 +++++++++++++++++++
 tb/tb_adc124_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc124_responder.sv
// SPI slave model of the ADC124 4-channel 12-bit converter: decodes the channel address
// from MOSI and returns the previously addressed channel on MISO. Optional checker: ADC124_RESP_FRAME_CHECK_EN.
module adc124_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [11:0] iCh0_data,
  input  logic [11:0] iCh1_data,
  input  logic [11:0] iCh2_data,
  input  logic [11:0] iCh3_data,
  input  logic        iADC124_CS_n,
  input  logic        iADC124_SCLK,
  input  logic        iADC124_MOSI,
  output logic        oADC124_MISO,
  output logic        oSample_valid,
  output logic [1:0]  oSample_ch,
  output logic [11:0] oSample_data,
  output logic        oFrame_err
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT
  } state_t;

  logic [SS-1:0] cs_sync_q;
  logic [SS-1:0] sclk_sync_q;
  logic [SS-1:0] mosi_sync_q;
  logic          cs_prev_q;
  logic          sclk_prev_q;

  logic          cs_lvl;
  logic          sclk_lvl;
  logic          mosi_lvl;
  logic          cs_fall;
  logic          cs_rise;
  logic          sclk_fall;
  logic          sclk_rise;

  state_t        state_q;
  logic [15:0]   tx_sreg_q;
  logic [4:0]    bit_cnt_q;
  logic [4:0]    bit_cnt_d;
  logic [1:0]    addr_shadow_q;
  logic [1:0]    cur_ch_q;
  logic [1:0]    frame_ch_q;
  logic [11:0]   frame_data_q;
  logic          valid_q;
  logic [1:0]    sample_ch_q;
  logic [11:0]   sample_data_q;
  logic [11:0]   ch_data_d;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SS-2:0], iADC124_CS_n};
      sclk_sync_q <= {sclk_sync_q[SS-2:0], iADC124_SCLK};
      mosi_sync_q <= {mosi_sync_q[SS-2:0], iADC124_MOSI};
      cs_prev_q   <= cs_sync_q[SS-1];
      sclk_prev_q <= sclk_sync_q[SS-1];
    end
  end

  assign cs_lvl    = cs_sync_q[SS-1];
  assign sclk_lvl  = sclk_sync_q[SS-1];
  assign mosi_lvl  = mosi_sync_q[SS-1];
  assign cs_fall   = cs_prev_q & ~cs_lvl;
  assign cs_rise   = ~cs_prev_q & cs_lvl;
  assign sclk_fall = sclk_prev_q & ~sclk_lvl;
  assign sclk_rise = ~sclk_prev_q & sclk_lvl;

  always_comb begin
    ch_data_d = iCh0_data;
    case (cur_ch_q)
      2'd0:    ch_data_d = iCh0_data;
      2'd1:    ch_data_d = iCh1_data;
      2'd2:    ch_data_d = iCh2_data;
      default: ch_data_d = iCh3_data;
    endcase
  end

  assign bit_cnt_d = bit_cnt_q + 5'd1;

  // MISO is the top bit of tx_sreg; clearing the register in IDLE holds MISO low.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q       <= ST_IDLE;
      tx_sreg_q     <= '0;
      bit_cnt_q     <= '0;
      addr_shadow_q <= '0;
      cur_ch_q      <= '0;
      frame_ch_q    <= '0;
      frame_data_q  <= '0;
      valid_q       <= 1'b0;
      sample_ch_q   <= '0;
      sample_data_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_sreg_q <= '0;
          if (cs_fall) begin
            tx_sreg_q    <= {4'b0000, ch_data_d};
            frame_ch_q   <= cur_ch_q;
            frame_data_q <= ch_data_d;
            bit_cnt_q    <= '0;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            tx_sreg_q     <= '0;
            bit_cnt_q     <= '0;
            addr_shadow_q <= '0;
            state_q       <= ST_IDLE;
          end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_d == 5'd4) addr_shadow_q[1] <= mosi_lvl;
            if (bit_cnt_d == 5'd5) addr_shadow_q[0] <= mosi_lvl;
            if (bit_cnt_d == 5'd16) begin
              cur_ch_q      <= addr_shadow_q;
              valid_q       <= 1'b1;
              sample_ch_q   <= frame_ch_q;
              sample_data_q <= frame_data_q;
              state_q       <= ST_WAIT;
            end
          // The falling edge ahead of the first rising edge launches DB15 (already on
          // MISO), so single and continuous frames shift out the same 16 bits.
          end else if (sclk_fall && (bit_cnt_q != 5'd0) && (bit_cnt_q < 5'd16)) begin
            tx_sreg_q <= {tx_sreg_q[14:0], 1'b0};
          end
        end
        ST_WAIT: begin
          if (cs_rise) begin
            tx_sreg_q <= '0;
            bit_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else if (sclk_fall) begin
            tx_sreg_q    <= {4'b0000, ch_data_d};
            frame_ch_q   <= cur_ch_q;
            frame_data_q <= ch_data_d;
            bit_cnt_q    <= '0;
            state_q      <= ST_SHIFT;
          end
        end
        default: begin
          tx_sreg_q <= '0;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign oADC124_MISO  = tx_sreg_q[15];
  assign oSample_valid = valid_q;
  assign oSample_ch    = sample_ch_q;
  assign oSample_data  = sample_data_q;

`ifdef ADC124_RESP_FRAME_CHECK_EN
  logic ferr_q;
  logic ferr_d;

  always_comb begin
    ferr_d = 1'b0;
    case (state_q)
      ST_IDLE:  ferr_d = sclk_fall & ~cs_fall;
      ST_SHIFT: ferr_d = cs_rise & (bit_cnt_q != 5'd0);
      default:  ferr_d = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) ferr_q <= 1'b0;
    else      ferr_q <= ferr_d;
  end

  assign oFrame_err = ferr_q;
`else
  assign oFrame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc124_responder.sv
// Self-checking bench for adc124_responder: SPI master model, sample scoreboard and
// per-scenario checks of MISO words, sample pulses and frame-error pulses.
module tb_adc124_responder;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [11:0] ch0, ch1, ch2, ch3;
  logic        cs_n, sclk, mosi;
  logic        miso, s_valid, f_err;
  logic [1:0]  s_ch;
  logic [11:0] s_data;

  always #5 iClk = ~iClk;

  adc124_responder #(.SYNC_STAGES(2)) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iCh0_data    (ch0),
    .iCh1_data    (ch1),
    .iCh2_data    (ch2),
    .iCh3_data    (ch3),
    .iADC124_CS_n (cs_n),
    .iADC124_SCLK (sclk),
    .iADC124_MOSI (mosi),
    .oADC124_MISO (miso),
    .oSample_valid(s_valid),
    .oSample_ch   (s_ch),
    .oSample_data (s_data),
    .oFrame_err   (f_err)
  );

`ifdef ADC124_RESP_FRAME_CHECK_EN
  localparam int unsigned ERR_EXP = 1;
`else
  localparam int unsigned ERR_EXP = 0;
`endif

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] data;
  } sample_t;

  sample_t     exp_q[$];
  sample_t     mon_e;
  int unsigned vstamp[$];
  int unsigned cyc = 0;
  int unsigned valid_cnt = 0;
  int unsigned ferr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] rx_word;

  // Scoreboard: every sample pulse pops the oldest expected frame result.
  always @(negedge iClk) begin
    cyc++;
    if (iRst !== 1'b1) begin
      if (s_valid === 1'b1) begin
        valid_cnt++;
        vstamp.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sample_unexpected: got ch=%0d data=%h, required no sample", s_ch, s_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (s_ch !== mon_e.ch || s_data !== mon_e.data) begin
            errors++;
            $display("FAIL sample: got ch=%0d data=%h, required ch=%0d data=%h",
                     s_ch, s_data, mon_e.ch, mon_e.data);
          end
        end
      end
      if (f_err === 1'b1) ferr_cnt++;
    end
  end

  task automatic sclk_bit(input logic m);
    sclk = 1'b0;
    mosi = m;
    repeat (8) @(negedge iClk);
    rx_word = {rx_word[14:0], miso};
    sclk = 1'b1;
    repeat (8) @(negedge iClk);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int unsigned first, input int unsigned n);
    for (int unsigned i = first; i < first + n; i++) sclk_bit(w[15-i]);
  endtask

  task automatic begin_frame();
    cs_n = 1'b0;
    rx_word = '0;
    repeat (8) @(negedge iClk);
  endtask

  task automatic end_frame();
    repeat (8) @(negedge iClk);
    cs_n = 1'b1;
    repeat (16) @(negedge iClk);
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b1;
    mosi = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0; ch3 = '0;
    repeat (4) @(negedge iClk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b, required 0", miso); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", s_valid); end
    checks++; if (s_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d, required 0", s_ch); end
    checks++; if (s_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h, required 000", s_data); end
    checks++; if (f_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", f_err); end
    iRst = 1'b0;
    repeat (8) @(negedge iClk);
  endtask

  task automatic test_single_frame();
    int unsigned v0;
    v0 = valid_cnt;
    ch0 = 12'hABC;
    exp_q.push_back('{ch: 2'd0, data: 12'hABC});
    begin_frame();
    shift_bits(16'h1000, 0, 16);
    end_frame();
    checks++; if (rx_word !== 16'h0ABC) begin errors++; $display("FAIL single_miso: got %h, required 0abc", rx_word); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL single_valid_count: got %0d, required %0d", valid_cnt - v0, 1); end
  endtask

  task automatic test_pipelining();
    logic [15:0] words [2];
    logic [15:0] exp_w [2];
    int unsigned v0;
    words[0] = 16'h1800; exp_w[0] = 16'h0123;
    words[1] = 16'h0000; exp_w[1] = 16'h0456;
    ch2 = 12'h123;
    ch3 = 12'h456;
    exp_q.push_back('{ch: 2'd2, data: 12'h123});
    exp_q.push_back('{ch: 2'd3, data: 12'h456});
    v0 = valid_cnt;
    for (int k = 0; k < 2; k++) begin
      begin_frame();
      shift_bits(words[k], 0, 16);
      end_frame();
      checks++;
      if (rx_word !== exp_w[k]) begin
        errors++; $display("FAIL pipeline_miso%0d: got %h, required %h", k, rx_word, exp_w[k]);
      end
    end
    checks++; if (valid_cnt !== v0 + 2) begin errors++; $display("FAIL pipeline_valid_count: got %0d, required 2", valid_cnt - v0); end
  endtask

  task automatic test_continuous();
    logic [15:0] words [3];
    logic [15:0] exp_w [3];
    words[0] = 16'h0800; exp_w[0] = 16'h03C5;
    words[1] = 16'h0800; exp_w[1] = 16'h07FF;
    words[2] = 16'h0000; exp_w[2] = 16'h07FF;
    ch0 = 12'h3C5;
    ch1 = 12'h7FF;
    exp_q.push_back('{ch: 2'd0, data: 12'h3C5});
    exp_q.push_back('{ch: 2'd1, data: 12'h7FF});
    exp_q.push_back('{ch: 2'd1, data: 12'h7FF});
    vstamp.delete();
    begin_frame();
    for (int k = 0; k < 3; k++) begin
      rx_word = '0;
      shift_bits(words[k], 0, 16);
      checks++;
      if (rx_word !== exp_w[k]) begin
        errors++; $display("FAIL cont_miso%0d: got %h, required %h", k, rx_word, exp_w[k]);
      end
    end
    end_frame();
    checks++;
    if (vstamp.size() != 3) begin
      errors++; $display("FAIL cont_valid_count: got %0d, required 3", vstamp.size());
    end else begin
      checks++;
      if (vstamp[1] - vstamp[0] != 256 || vstamp[2] - vstamp[1] != 256) begin
        errors++; $display("FAIL cont_spacing: got %0d,%0d cycles, required 256,256",
                           vstamp[1] - vstamp[0], vstamp[2] - vstamp[1]);
      end
    end
  endtask

  task automatic test_abort();
    int unsigned v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    begin_frame();
    shift_bits(16'h1800, 0, 9);
    end_frame();
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL abort_valid: got %0d pulses, required 0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== ERR_EXP) begin errors++; $display("FAIL abort_ferr: got %0d pulses, required %0d", ferr_cnt - f0, ERR_EXP); end
    exp_q.push_back('{ch: 2'd0, data: 12'h3C5});
    begin_frame();
    shift_bits(16'h1800, 0, 16);
    end_frame();
    checks++; if (rx_word !== 16'h03C5) begin errors++; $display("FAIL abort_next_miso: got %h, required 03c5", rx_word); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL abort_next_valid: got %0d, required 1", valid_cnt - v0); end
  endtask

  task automatic test_idle_clock();
    int unsigned v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    sclk = 1'b0;
    repeat (8) @(negedge iClk);
    sclk = 1'b1;
    repeat (16) @(negedge iClk);
    checks++; if (ferr_cnt - f0 !== ERR_EXP) begin errors++; $display("FAIL idle_sclk_ferr: got %0d pulses, required %0d", ferr_cnt - f0, ERR_EXP); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL idle_sclk_valid: got %0d pulses, required 0", valid_cnt - v0); end
  endtask

  task automatic test_reset_mid();
    int unsigned v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    ch3 = 12'hFFF;
    begin_frame();
    shift_bits(16'h1000, 0, 6);
    checks++; if (rx_word !== 16'h0003) begin errors++; $display("FAIL midrst_prefix: got %h, required 0003", rx_word); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL midrst_miso_before: got %b, required 1", miso); end
    iRst = 1'b1;
    cs_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge iClk);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso_in_reset: got %b, required 0", miso); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_in_reset: got %b, required 0", s_valid); end
    end
    iRst = 1'b0;
    repeat (16) @(negedge iClk);
    ch0 = 12'h5A5;
    exp_q.push_back('{ch: 2'd0, data: 12'h5A5});
    begin_frame();
    shift_bits(16'h0000, 0, 3);
    ch0 = 12'h000;
    shift_bits(16'h0000, 3, 13);
    end_frame();
    checks++; if (rx_word !== 16'h05A5) begin errors++; $display("FAIL midrst_next_miso: got %h, required 05a5", rx_word); end
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL midrst_valid_count: got %0d, required 1", valid_cnt - v0); end
    checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL midrst_ferr: got %0d pulses, required 0", ferr_cnt - f0); end
  endtask

  initial begin
    iRst = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b1;
    mosi = 1'b0;
    rx_word = '0;
    @(negedge iClk);
    test_reset();
    test_single_frame();
    test_pipelining();
    test_continuous();
    test_abort();
    test_idle_clock();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending samples, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
